// File: rtl/posit_dot_sched_if.sv
// Handshake bundle between the two operand front ends, the result consumer and
// the posit dot-product scheduler.
interface posit_dot_sched_if #(
  parameter int unsigned LEN_W = 8
);
  logic             req0_start_valid;
  logic             req0_start_ready;
  logic [LEN_W-1:0] req0_len;
  logic             req0_op_valid;
  logic             req0_op_ready;
  logic [7:0]       req0_a;
  logic [7:0]       req0_b;
  logic             req1_start_valid;
  logic             req1_start_ready;
  logic [LEN_W-1:0] req1_len;
  logic             req1_op_valid;
  logic             req1_op_ready;
  logic [7:0]       req1_a;
  logic [7:0]       req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_id;
  logic             busy;
  logic [1:0]       grant;

  modport slave (
    input  req0_start_valid, req0_len, req0_op_valid, req0_a, req0_b,
    input  req1_start_valid, req1_len, req1_op_valid, req1_a, req1_b,
    input  res_ready,
    output req0_start_ready, req0_op_ready, req1_start_ready, req1_op_ready,
    output res_valid, res_data, res_id, busy, grant
  );

  modport master (
    output req0_start_valid, req0_len, req0_op_valid, req0_a, req0_b,
    output req1_start_valid, req1_len, req1_op_valid, req1_a, req1_b,
    output res_ready,
    input  req0_start_ready, req0_op_ready, req1_start_ready, req1_op_ready,
    input  res_valid, res_data, res_id, busy, grant
  );
endinterface

// File: rtl/posit_dot_sched.sv
// Two-requester job scheduler sharing one combinational posit8 (es=0) MAC;
// owns the 8-bit accumulator and returns each job's result tagged with its requester.
module posit_mac_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] c_i,
  output logic [7:0] y_o
);
  logic        sa, sb, sc, za, zb, zc, nar, neg;
  int          ka, kb, kc, e;
  int unsigned ld;
  logic [5:0]  ma, mb, mc;
  logic [11:0] prod;
  logic [38:0] pmag, cmag, mag;
  logic [37:0] norm;
  logic signed [40:0] pv, cv, sum;
  logic [47:0] tmp;
  logic [6:0]  body, pos;
  logic        rnd;

  // Decode to sign, scale 2^k and 1.fffff mantissa; zero and NaR flag z with k=0.
  function automatic void dec(input logic [7:0] x, output logic s, output logic z,
                              output int k, output logic [5:0] m);
    logic [6:0] mg;
    logic       first, stop;
    int         run;
    mg    = x[7] ? 7'(~x + 8'd1) : x[6:0];
    first = mg[6];
    run   = 0;
    stop  = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (!stop && (mg[6-i] == first)) run++;
      else stop = 1'b1;
    end
    s = x[7];
    z = (x[6:0] == 7'd0);
    k = z ? 0 : (first ? run - 1 : -run);
    m = {1'b1, 5'(7'(mg << (run + 1)) >> 2)};
  endfunction

  always_comb begin
    dec(a_i, sa, za, ka, ma);
    dec(b_i, sb, zb, kb, mb);
    dec(c_i, sc, zc, kc, mc);
    nar  = (a_i == 8'h80) || (b_i == 8'h80) || (c_i == 8'h80);
    prod = 12'(ma) * 12'(mb);
    // Exact fixed-point sum, LSB weight 2^-22.
    pmag = (za || zb) ? '0 : (39'(prod) << (ka + kb + 12));
    cmag = zc ? '0 : (39'(mc) << (kc + 17));
    pv   = (sa ^ sb) ? -$signed({2'b00, pmag}) : $signed({2'b00, pmag});
    cv   = sc ? -$signed({2'b00, cmag}) : $signed({2'b00, cmag});
    sum  = pv + cv;
    neg  = sum[40];
    mag  = neg ? 39'(-sum) : sum[38:0];
    ld   = 0;
    for (int unsigned i = 0; i < 39; i++) begin
      if (mag[i]) ld = i;
    end
    e    = int'(ld) - 22;
    norm = 38'(mag << (38 - ld));
    // Regime bits prepended to the fraction, then RNE on the bit pattern.
    if (e >= 0) tmp = 48'($signed({2'b10, norm, 8'd0}) >>> e);
    else        tmp = {2'b01, norm, 8'd0} >> (-e - 1);
    body = tmp[47:41];
    rnd  = tmp[40] & ((|tmp[39:0]) | body[0]);
    if (e >= 6)       pos = 7'h7F;
    else if (e < -6)  pos = 7'h01;
    else              pos = body + {6'd0, rnd};
    y_o = '0;
    if (nar)               y_o = 8'h80;
    else if (mag != '0)    y_o = neg ? (~{1'b0, pos} + 8'd1) : {1'b0, pos};
  end
endmodule

module posit_dot_sched #(
  parameter int unsigned LEN_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  posit_dot_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d, res_data_q, res_data_d;
  logic [LEN_W-1:0] count_q, count_d, win_len;
  logic             rr_q, rr_d, owner_q, owner_d, res_id_q, res_id_d;
  logic             win, own_op_valid;
  logic [7:0]       mac_a, mac_b, mac_y;

  posit_mac_8bit u_mac (
    .a_i (mac_a),
    .b_i (mac_b),
    .c_i (acc_q),
    .y_o (mac_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;

    bus.req0_start_ready = 1'b0;
    bus.req1_start_ready = 1'b0;
    bus.req0_op_ready    = 1'b0;
    bus.req1_op_ready    = 1'b0;
    bus.res_valid        = 1'b0;
    bus.grant            = 2'b00;
    bus.res_data         = res_data_q;
    bus.res_id           = res_id_q;
    bus.busy             = (state_q != IDLE);

    // A lone requester wins outright; a tie goes to rr_q.
    win          = (bus.req0_start_valid && bus.req1_start_valid) ? rr_q : bus.req1_start_valid;
    win_len      = win ? bus.req1_len : bus.req0_len;
    mac_a        = owner_q ? bus.req1_a : bus.req0_a;
    mac_b        = owner_q ? bus.req1_b : bus.req0_b;
    own_op_valid = owner_q ? bus.req1_op_valid : bus.req0_op_valid;

    case (state_q)
      IDLE: begin
        if (bus.req0_start_valid || bus.req1_start_valid) begin
          bus.req0_start_ready = ~win;
          bus.req1_start_ready = win;
          acc_d   = '0;
          count_d = win_len;
          owner_d = win;
          if (win_len == '0) begin
            state_d    = DONE;
            res_data_d = '0;
            res_id_d   = win;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        bus.grant         = owner_q ? 2'b10 : 2'b01;
        bus.req0_op_ready = ~owner_q;
        bus.req1_op_ready = owner_q;
        if (own_op_valid) begin
          acc_d   = mac_y;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d    = DONE;
            res_data_d = mac_y;
            res_id_d   = owner_q;
          end
        end
      end
      DONE: begin
        bus.grant     = owner_q ? 2'b10 : 2'b01;
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_posit_dot_sched.sv
// Directed scoreboard bench for the posit dot-product scheduler.
module tb_posit_dot_sched;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  posit_dot_sched_if #(.LEN_W(8)) bus ();
  posit_dot_sched #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic id; logic [7:0] data; } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic id, input logic [7:0] d);
    return exp_t'{id: id, data: d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sready(input int id);
    return (id == 0) ? bus.req0_start_ready : bus.req1_start_ready;
  endfunction
  function automatic logic opready(input int id);
    return (id == 0) ? bus.req0_op_ready : bus.req1_op_ready;
  endfunction

  task automatic drive_start(input int id, input logic v, input logic [7:0] len);
    if (id == 0) begin bus.req0_start_valid = v; bus.req0_len = len; end
    else         begin bus.req1_start_valid = v; bus.req1_len = len; end
  endtask

  task automatic drive_op(input int id, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin bus.req0_op_valid = v; bus.req0_a = a; bus.req0_b = b; end
    else         begin bus.req1_op_valid = v; bus.req1_a = a; bus.req1_b = b; end
  endtask

  // Start a job, then feed its operand pairs; lat = cycles from start handshake to now.
  task automatic run_job(input int id, input int len, input logic [7:0] av[8],
                         input logic [7:0] bv[8], input bit stall, output int lat);
    int   tries, i, t_hs;
    logic v;
    tries = 0;
    @(negedge clk);
    drive_start(id, 1'b1, len[7:0]);
    #1;
    while (!sready(id) && tries < 50) begin
      @(negedge clk); #1; tries++;
    end
    chk("start_accept", sready(id), 1);
    t_hs = cyc;
    @(negedge clk);
    drive_start(id, 1'b0, 8'd0);
    i = 0;
    tries = 0;
    while (i < len && tries < 200) begin
      v = stall ? (tries % 2 == 0) : 1'b1;
      drive_op(id, v, av[i], bv[i]);
      #1;
      if (v && opready(id)) i++;
      tries++;
      @(negedge clk);
    end
    drive_op(id, 1'b0, 8'd0, 8'd0);
    chk("ops_consumed", i, len);
    lat = cyc - t_hs;
  endtask

  task automatic pop_cmp();
    exp_t e;
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_data", bus.res_data, e.data);
      chk("res_id", bus.res_id, e.id);
    end
  endtask

  task automatic get_result();
    int tries;
    tries = 0;
    #1;
    while (!bus.res_valid && tries < 300) begin
      @(negedge clk); #1; tries++;
    end
    chk("res_valid", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    #1;
    pop_cmp();
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ones[8], canc[8], nar_a[8];
    int         lat, w, tries;
    logic [7:0] d0;
    logic       id0;
    ones  = '{default: 8'h40};
    canc  = '{0: 8'h40, 1: 8'hC0, default: 8'h00};
    nar_a = '{1: 8'h80, default: 8'h40};
    rst = 1'b1;
    bus.res_ready = 1'b0;
    drive_start(0, 1'b0, 8'd0); drive_start(1, 1'b0, 8'd0);
    drive_op(0, 1'b0, 8'd0, 8'd0); drive_op(1, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_start_ready", {bus.req1_start_ready, bus.req0_start_ready}, 0);
    chk("rst_op_ready", {bus.req1_op_ready, bus.req0_op_ready}, 0);

    // 1+1+1 = 3.0
    sb.push_back(mk(1'b0, 8'h68));
    run_job(0, 3, ones, ones, 1'b0, lat);
    #1;
    chk("lat_len3", lat, 4);
    chk("valid_at_T+4", bus.res_valid, 1);
    get_result();

    // 1 + (-1) = 0
    sb.push_back(mk(1'b1, 8'h00));
    run_job(1, 2, canc, ones, 1'b0, lat);
    get_result();

    sb.push_back(mk(1'b0, 8'h00));
    run_job(0, 0, ones, ones, 1'b0, lat);
    #1;
    chk("lat_len0", lat, 1);
    chk("valid_at_T+1", bus.res_valid, 1);
    get_result();

    sb.push_back(mk(1'b1, 8'h80));
    run_job(1, 3, nar_a, ones, 1'b0, lat);
    get_result();

    // Stalled operand stream, then a held result with requester 1 waiting.
    sb.push_back(mk(1'b0, 8'h68));
    run_job(0, 3, ones, ones, 1'b1, lat);
    #1;
    chk("lat_stalled", lat, 6);
    chk("valid_stalled", bus.res_valid, 1);
    d0  = bus.res_data;
    id0 = bus.res_id;
    drive_start(1, 1'b1, 8'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, d0);
      chk("hold_id", bus.res_id, id0);
      chk("hold_no_start", sready(1), 0);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("no_start_at_res_hs", sready(1), 0);
    pop_cmp();
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("start_after_done", sready(1), 1);
    sb.push_back(mk(1'b1, 8'h40));
    @(negedge clk);
    drive_start(1, 1'b0, 8'd0);
    drive_op(1, 1'b1, 8'h40, 8'h40);
    #1;
    chk("op_ready_owner1", opready(1), 1);
    chk("op_ready_other0", opready(0), 0);
    @(negedge clk);
    drive_op(1, 1'b0, 8'd0, 8'd0);
    get_result();

    // Reset in the middle of a job.
    @(negedge clk);
    drive_start(0, 1'b1, 8'd3);
    #1;
    chk("mid_start", sready(0), 1);
    @(negedge clk);
    drive_start(0, 1'b0, 8'd0);
    drive_op(0, 1'b1, 8'h40, 8'h40);
    #1;
    chk("mid_busy", bus.busy, 1);
    chk("mid_grant", bus.grant, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_op_ready", bus.req0_op_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_op(0, 1'b0, 8'd0, 8'd0);
    #1;
    chk("postrst_busy", bus.busy, 0);
    chk("postrst_res_valid", bus.res_valid, 0);
    sb.push_back(mk(1'b0, 8'h40));
    run_job(0, 1, ones, ones, 1'b0, lat);
    get_result();

    // Round-robin with both requesters asserting start continuously.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_start(0, 1'b1, 8'd1);
    drive_start(1, 1'b1, 8'd1);
    drive_op(0, 1'b1, 8'h60, 8'h60);
    drive_op(1, 1'b1, 8'h60, 8'h60);
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      tries = 0;
      #1;
      while (!(sready(0) || sready(1)) && tries < 50) begin
        @(negedge clk); #1; tries++;
      end
      chk("rr_win", sready(w), 1);
      chk("rr_lose", sready(1 - w), 0);
      sb.push_back(mk(w[0], 8'h70));
      @(negedge clk); #1;
      chk("rr_grant", bus.grant, (w == 1) ? 2'b10 : 2'b01);
      chk("rr_op_ready_win", opready(w), 1);
      chk("rr_op_ready_lose", opready(1 - w), 0);
      chk("rr_start_ready_lose", sready(1 - w), 0);
      get_result();
    end
    drive_start(0, 1'b0, 8'd0);
    drive_start(1, 1'b0, 8'd0);
    drive_op(0, 1'b0, 8'd0, 8'd0);
    drive_op(1, 1'b0, 8'd0, 8'd0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
